// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS stopwatch with run/pause, field adjust and blinking, driving four active-low 7-segment codes
// Ports: clk/rst (sync, active-high); tick_1hz count enable; tick_2hz adjust increment enable;
//        tick_blink blink-phase toggle; pause run toggle pulse; adj adjust-mode level; sel 0=minutes 1=seconds;
//        seg_min_top/seg_min_bot/seg_sec_top/seg_sec_bot registered {dp,g,f,e,d,c,b,a}; running run flag.
module stopwatch_counter #(
   parameter int         MIN_MAX   = 99,
   parameter logic [7:0] SEG_BLANK = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   input  logic       tick_blink,
   input  logic       pause,
   input  logic       adj,
   input  logic       sel,
   output logic [7:0] seg_min_top,
   output logic [7:0] seg_min_bot,
   output logic [7:0] seg_sec_top,
   output logic [7:0] seg_sec_bot,
   output logic       running
);
   logic [3:0] sec_u_q, sec_u_d, sec_t_q, sec_t_d, min_u_q, min_u_d, min_t_q, min_t_d;
   logic       running_q, running_d, blink_q, blink_d, adj_q, sel_q;
   logic [7:0] smt_q, smt_d, smb_q, smb_d, sst_q, sst_d, ssb_q, ssb_d;
   logic       at_max, sec_max, inc_sec, inc_min, blank_min, blank_sec;
   function automatic logic [7:0] enc(input logic [3:0] d);
      case (d)
         4'd1:    enc = 8'hF9;
         4'd2:    enc = 8'hA4;
         4'd3:    enc = 8'hB0;
         4'd4:    enc = 8'h99;
         4'd5:    enc = 8'h92;
         4'd6:    enc = 8'h82;
         4'd7:    enc = 8'hF8;
         4'd8:    enc = 8'h80;
         4'd9:    enc = 8'h90;
         default: enc = 8'hC0;
      endcase
   endfunction
   always_comb begin
      at_max    = min_t_q == 4'(MIN_MAX / 10) && min_u_q == 4'(MIN_MAX % 10);
      sec_max   = sec_t_q == 4'd5 && sec_u_q == 4'd9;
      // in adjust mode the 2 Hz tick bumps only the selected field, so minutes never see a seconds carry
      inc_sec   = adj ? tick_2hz & sel : tick_1hz & running_q;
      inc_min   = adj ? tick_2hz & ~sel : tick_1hz & running_q & sec_max;
      sec_u_d   = inc_sec ? (sec_u_q == 4'd9 ? 4'd0 : sec_u_q + 4'd1) : sec_u_q;
      sec_t_d   = inc_sec && sec_u_q == 4'd9 ? (sec_t_q == 4'd5 ? 4'd0 : sec_t_q + 4'd1) : sec_t_q;
      min_u_d   = inc_min ? (at_max || min_u_q == 4'd9 ? 4'd0 : min_u_q + 4'd1) : min_u_q;
      min_t_d   = inc_min ? (at_max ? 4'd0 : min_u_q == 4'd9 ? min_t_q + 4'd1 : min_t_q) : min_t_q;
      running_d = running_q ^ pause;
      // entering adjust forces the visible phase so the field shows at once
      blink_d   = adj & ~adj_q ? 1'b0 : blink_q ^ tick_blink;
      blank_min = adj_q & blink_q & ~sel_q;
      blank_sec = adj_q & blink_q & sel_q;
      smt_d     = blank_min ? SEG_BLANK : enc(min_t_q);
      smb_d     = blank_min ? SEG_BLANK : enc(min_u_q);
      sst_d     = blank_sec ? SEG_BLANK : enc(sec_t_q);
      ssb_d     = blank_sec ? SEG_BLANK : enc(sec_u_q);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sec_u_q   <= '0;
         sec_t_q   <= '0;
         min_u_q   <= '0;
         min_t_q   <= '0;
         running_q <= 1'b0;
         blink_q   <= 1'b0;
         adj_q     <= 1'b0;
         sel_q     <= 1'b0;
         smt_q     <= 8'hC0;
         smb_q     <= 8'hC0;
         sst_q     <= 8'hC0;
         ssb_q     <= 8'hC0;
      end else begin
         sec_u_q   <= sec_u_d;
         sec_t_q   <= sec_t_d;
         min_u_q   <= min_u_d;
         min_t_q   <= min_t_d;
         running_q <= running_d;
         blink_q   <= blink_d;
         adj_q     <= adj;
         sel_q     <= sel;
         smt_q     <= smt_d;
         smb_q     <= smb_d;
         sst_q     <= sst_d;
         ssb_q     <= ssb_d;
      end
   end
   assign seg_min_top = smt_q;
   assign seg_min_bot = smb_q;
   assign seg_sec_top = sst_q;
   assign seg_sec_bot = ssb_q;
   assign running     = running_q;
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed plus random stimulus checked against a seconds/minutes arithmetic model
module tb_stopwatch_counter;
   localparam int MIN_MAX = 99;
   localparam logic [7:0] ENC [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   logic clk = 1'b0;
   logic rst = 1'b0, tick_1hz = 1'b0, tick_2hz = 1'b0, tick_blink = 1'b0, pause = 1'b0, adj = 1'b0, sel = 1'b0;
   logic [7:0] seg_min_top, seg_min_bot, seg_sec_top, seg_sec_bot;
   logic running;
   int errors = 0, checks = 0;
   int m_min = 0, m_sec = 0;
   bit m_run = 0, m_blink = 0, m_adj_q = 0, m_sel_q = 0;
   logic [31:0] m_seg;
   stopwatch_counter #(.MIN_MAX(MIN_MAX), .SEG_BLANK(8'hFF)) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_blink(tick_blink),
      .pause(pause), .adj(adj), .sel(sel), .seg_min_top(seg_min_top), .seg_min_bot(seg_min_bot),
      .seg_sec_top(seg_sec_top), .seg_sec_bot(seg_sec_bot), .running(running)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask
   function automatic logic [31:0] disp();
      bit bm = m_adj_q && m_blink && !m_sel_q;
      bit bs = m_adj_q && m_blink && m_sel_q;
      return {bm ? 8'hFF : ENC[m_min / 10], bm ? 8'hFF : ENC[m_min % 10],
              bs ? 8'hFF : ENC[m_sec / 10], bs ? 8'hFF : ENC[m_sec % 10]};
   endfunction
   function automatic logic [31:0] segs();
      return {seg_min_top, seg_min_bot, seg_sec_top, seg_sec_bot};
   endfunction
   task automatic step(input bit r, input bit t1, input bit t2, input bit tb, input bit p, input bit a, input bit s);
      int t;
      rst = r; tick_1hz = t1; tick_2hz = t2; tick_blink = tb; pause = p; adj = a; sel = s;
      @(posedge clk);
      if (r) begin
         m_seg = 32'hC0C0C0C0;
         m_min = 0; m_sec = 0; m_run = 0; m_blink = 0; m_adj_q = 0; m_sel_q = 0;
      end else begin
         m_seg = disp();
         if (a) begin
            if (t2 && s) m_sec = (m_sec + 1) % 60;
            if (t2 && !s) m_min = (m_min + 1) % (MIN_MAX + 1);
         end else if (t1 && m_run) begin
            t = (m_min * 60 + m_sec + 1) % ((MIN_MAX + 1) * 60);
            m_min = t / 60;
            m_sec = t % 60;
         end
         if (p) m_run = !m_run;
         if (a && !m_adj_q) m_blink = 0;
         else if (tb) m_blink = !m_blink;
         m_adj_q = a;
         m_sel_q = s;
      end
      #1;
      check("segs", segs(), m_seg);
      check("running", {31'd0, running}, {31'd0, m_run});
   endtask
   task automatic idle(input bit a, input bit s);
      step(0, 0, 0, 0, 0, a, s);
   endtask
   task automatic preload(input int mm, input int ss);
      for (int i = 0; i < 200 && m_min != mm; i++) step(0, 0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 200 && m_sec != ss; i++) step(0, 0, 1, 0, 0, 1, 1);
      check("preload", m_min * 60 + m_sec, mm * 60 + ss);
   endtask
   initial begin
      step(1, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2);
      step(1, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2, 0, 0);
      check("rst_segs", segs(), 32'hC0C0C0C0);
      for (int i = 0; i < 3; i++) begin step(0, 1, 0, 0, 0, 0, 0); idle(0, 0); end
      check("paused_hold", segs(), 32'hC0C0C0C0);
      step(0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 61; i++) begin step(0, 1, 0, 0, 0, 0, 0); idle(0, 0); end
      check("t_01_01", segs(), 32'hC0F9C0F9);
      preload(99, 58);
      idle(0, 0);
      step(0, 1, 0, 0, 0, 0, 0); idle(0, 0);
      check("t_99_59", segs(), 32'h90909290);
      step(0, 1, 0, 0, 0, 0, 0); idle(0, 0);
      check("wrap_00_00", segs(), 32'hC0C0C0C0);
      preload(5, 59);
      step(0, 1, 1, 0, 0, 1, 1); idle(1, 1);
      check("adj_sec_wrap", segs(), 32'hC092C0C0);
      idle(1, 0);
      step(0, 0, 0, 1, 0, 1, 0); idle(1, 0);
      check("blank_min", segs(), 32'hFFFFC0C0);
      step(0, 0, 0, 1, 0, 1, 0); idle(1, 0);
      check("unblank_min", segs(), 32'hC092C0C0);
      idle(0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      check("paused", {31'd0, running}, 32'd0);
      step(0, 1, 0, 0, 1, 0, 0);
      check("pause_t1_run", {31'd0, running}, 32'd1);
      idle(0, 0);
      check("pause_t1_noinc", segs(), 32'hC092C0C0);
      preload(12, 34);
      idle(0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      check("rst_mid", segs(), 32'hC0C0C0C0);
      for (int i = 0; i < 3000; i++)
         step($urandom % 300 == 0, $urandom % 4 == 0, $urandom % 3 == 0, $urandom % 5 == 0,
              $urandom % 40 == 0, ($urandom % 50 == 0) ? !adj : adj, ($urandom % 30 == 0) ? !sel : sel);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Produces the four 8-bit segment codes that the display multiplexer scans: MM:SS time in BCD, encoded for active-low 7-segment digits.
- Owns run/pause state, adjust mode (fast increment of the selected field) and blanking of the selected field while adjusting.
- Sits between the tick/enable generator plus button conditioning and the display mux, in the single fast clock domain.

Parameters:
- MIN_MAX, 99, highest minutes value before wrapping to 00 (legal range 9..99).
- SEG_BLANK, 8'hFF, segment code driven for a blanked digit.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- tick_1hz  input  1  one-cycle enable; advances time while running.
- tick_2hz  input  1  one-cycle enable; adjust-mode increment rate.
- tick_blink  input  1  one-cycle enable; toggles the blink phase.
- pause  input  1  one-cycle pulse from the conditioned button; toggles run.
- adj  input  1  level; 1 = adjust mode.
- sel  input  1  level; 0 = adjust minutes, 1 = adjust seconds.
- seg_min_top  output  8  minutes tens digit, active-low {dp,g,f,e,d,c,b,a}.
- seg_min_bot  output  8  minutes units digit.
- seg_sec_top  output  8  seconds tens digit.
- seg_sec_bot  output  8  seconds units digit.
- running  output  1  current run flag.

Behaviour:
- Reset values: time 00:00; running=0; blink_phase=0; all four seg outputs 8'hC0 ("0", dp off). rst takes priority over every other input on the same edge and may arrive at any time.
- State is held as four BCD registers: sec_u (0-9), sec_t (0-5), min_u (0-9), min_t (0-9). They never hold an illegal code.
- Run flag: on a pause pulse, running <= ~running. This applies in both modes. A tick_1hz on the same edge as pause uses the pre-toggle value of running.
- Modes, with adj sampled each cycle:
  - COUNT (adj=0): on tick_1hz with running=1, add 1 second. sec_u 9->0 carries to sec_t; sec_t 5 with a carry ->0 and carries to minutes; min_u 9->0 carries to min_t. At MIN_MAX:59 the next tick gives 00:00, with no sticky overflow.
  - ADJUST (adj=1): normal counting is suspended. tick_1hz is ignored even when running=1. On tick_2hz, the selected field increments by 1 without carrying into the other field. Seconds wrap 59->00. Minutes wrap MIN_MAX->00. Leaving adjust mode resumes counting from the adjusted value on the next qualifying tick_1hz.
  - tick_1hz and tick_2hz on the same edge: only the action for the current mode is taken. A sel change takes effect on the next tick_2hz.
- Blink: blink_phase toggles on every tick_blink regardless of mode. It is cleared to 0 on entry into adjust mode (the first cycle with adj=1 after adj=0), so the field is visible immediately. In adjust mode with blink_phase=1, both digits of the selected field output SEG_BLANK and the other field displays normally. In COUNT mode nothing is blanked.
- Encoding: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90. dp is always 1 (off).
- Latency: seg outputs are registered. A BCD change committed on edge N appears on the seg outputs after edge N+1. A blink or mode change also takes one cycle to reach the outputs.
- All four seg outputs update together on the same edge, so the display never shows a mixed old/new pair.

Test Plan:
- Apply rst for 2 cycles with random inputs -> all segs C0, running=0; tick_1hz pulses while paused leave 00:00.
- One pause pulse, then 61 tick_1hz pulses -> display 01:01 (seg_min_top C0, seg_min_bot F9, seg_sec_top C0, seg_sec_bot F9), visible 1 cycle after the last tick.
- Preload 99:58 via adjust mode, then run with 2 tick_1hz pulses -> 99:59, then 00:00 (all C0).
- adj=1, sel=1, seconds at 59, one tick_2hz -> seconds 00 and minutes unchanged; concurrent tick_1hz has no effect.
- adj=1, sel=0, blink_phase set to 1 by tick_blink -> min segs FF and sec segs show their value; next tick_blink restores the min digits.
- pause and tick_1hz on the same edge from running=0 -> no increment and running=1; rst asserted mid-count at 12:34 -> 00:00, C0 outputs on the next edge.
